// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: majority-vote bit sampling, LSB-first
// deserialisation and start/parity/stop checking, driven by an external
// edge/bit counter that it enables while a frame is in progress.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  clk_RX,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    edge_cnt,
  input  logic [3:0]            bit_cnt,
  input  logic                  edge_cnt_max,
  output logic                  edge_cnt_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                next_state;

  logic [PRESC_W-1:0]    eff_prescale;
  logic [PRESC_W-1:0]    half_prescale;
  logic [2:0]            samples;
  logic                  sampled_bit;
  logic                  majority;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] p_data_d;
  logic                  perr;
  logic                  perr_d;
  logic                  par_en_q;
  logic                  par_en_d;
  logic                  par_typ_q;
  logic                  par_typ_d;
  logic                  data_valid_d;
  logic                  par_err_d;
  logic                  stp_err_d;
  logic                  strt_glitch_d;

  // Unsupported oversampling ratios fall back to 8
  always_comb begin
    eff_prescale = PRESC_W'(8);
    if ((prescale == PRESC_W'(16)) || (prescale == PRESC_W'(32))) begin
      eff_prescale = prescale;
    end
  end

  assign half_prescale = eff_prescale >> 1;
  assign majority      = (samples[0] & samples[1]) |
                         (samples[0] & samples[2]) |
                         (samples[1] & samples[2]);

  // Three captures around mid-bit, voted one edge after the last capture
  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      samples     <= '0;
      sampled_bit <= 1'b0;
    end else if (state != IDLE) begin
      if (edge_cnt == (half_prescale - PRESC_W'(2))) samples[0] <= RX_IN;
      if (edge_cnt == (half_prescale - PRESC_W'(1))) samples[1] <= RX_IN;
      if (edge_cnt == half_prescale)                 samples[2] <= RX_IN;
      if (edge_cnt == (half_prescale + PRESC_W'(1))) sampled_bit <= majority;
    end
  end

  // State register
  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; every bit-level decision is taken on the last edge of the bit
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!RX_IN) next_state = START;
      end
      START: begin
        if (edge_cnt_max && (bit_cnt == '0)) begin
          next_state = sampled_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (edge_cnt_max && (bit_cnt == BIT_CNT_W'(DATA_WIDTH))) begin
          next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (edge_cnt_max) next_state = STOP;
      end
      STOP: begin
        if (edge_cnt_max) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and pulse decode for the next cycle
  always_comb begin
    shift_d       = shift_reg;
    p_data_d      = P_DATA;
    perr_d        = perr;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    data_valid_d  = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    strt_glitch_d = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end
      end
      START: begin
        if (edge_cnt_max && (bit_cnt == '0) && sampled_bit) strt_glitch_d = 1'b1;
      end
      DATA: begin
        if (edge_cnt_max) shift_d = {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
      end
      PARITY: begin
        if (edge_cnt_max && (sampled_bit != ((^shift_reg) ^ par_typ_q))) begin
          par_err_d = 1'b1;
          perr_d    = 1'b1;
        end
      end
      STOP: begin
        if (edge_cnt_max) begin
          perr_d = 1'b0;
          if (!sampled_bit) begin
            stp_err_d = 1'b1;
          end else if (!perr) begin
            p_data_d     = shift_reg;
            data_valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and frame context
  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      shift_reg       <= '0;
      P_DATA          <= '0;
      perr            <= 1'b0;
      par_en_q        <= 1'b0;
      par_typ_q       <= 1'b0;
      data_valid      <= 1'b0;
      par_err         <= 1'b0;
      stp_err         <= 1'b0;
      strt_glitch     <= 1'b0;
      edge_cnt_enable <= 1'b0;
    end else begin
      shift_reg       <= shift_d;
      P_DATA          <= p_data_d;
      perr            <= perr_d;
      par_en_q        <= par_en_d;
      par_typ_q       <= par_typ_d;
      data_valid      <= data_valid_d;
      par_err         <= par_err_d;
      stp_err         <= stp_err_d;
      strt_glitch     <= strt_glitch_d;
      edge_cnt_enable <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: models the edge/bit counter, drives serial
// frames and scoreboards every output pulse against a frame-level model.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  localparam int K_VALID  = 0;
  localparam int K_PAR    = 1;
  localparam int K_STP    = 2;
  localparam int K_GLITCH = 3;

  logic          clk_RX   = 1'b0;
  logic          rst      = 1'b1;
  logic          RX_IN    = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic          PAR_EN   = 1'b0;
  logic          PAR_TYP  = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          edge_cnt_max;
  logic          edge_cnt_enable;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          strt_glitch;

  typedef struct {
    int          kind;
    int          cyc;
    logic [7:0]  pdata;
  } ev_t;

  ev_t        expq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] model_pdata = 8'h00;

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk_RX          (clk_RX),
    .rst             (rst),
    .RX_IN           (RX_IN),
    .prescale        (prescale),
    .PAR_EN          (PAR_EN),
    .PAR_TYP         (PAR_TYP),
    .edge_cnt        (edge_cnt),
    .bit_cnt         (bit_cnt),
    .edge_cnt_max    (edge_cnt_max),
    .edge_cnt_enable (edge_cnt_enable),
    .P_DATA          (P_DATA),
    .data_valid      (data_valid),
    .par_err         (par_err),
    .stp_err         (stp_err),
    .strt_glitch     (strt_glitch)
  );

  always #5 clk_RX = ~clk_RX;

  always @(posedge clk_RX) cyc <= cyc + 1;

  function automatic int eff_of(input logic [PW-1:0] p);
    return ((p == PW'(16)) || (p == PW'(32))) ? int'(p) : 8;
  endfunction

  // Edge/bit counter companion: free-runs while enabled, holds 0 otherwise
  always @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!edge_cnt_enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (int'(edge_cnt) == eff_of(prescale) - 1) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + PW'(1);
    end
  end

  assign edge_cnt_max = (int'(edge_cnt) == eff_of(prescale) - 1);

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_p_data"},      int'(P_DATA), 0);
    check({tag, "_data_valid"},  int'(data_valid), 0);
    check({tag, "_par_err"},     int'(par_err), 0);
    check({tag, "_stp_err"},     int'(stp_err), 0);
    check({tag, "_strt_glitch"}, int'(strt_glitch), 0);
    check({tag, "_enable"},      int'(edge_cnt_enable), 0);
  endtask

  // Monitor: every pulse pops one expected event
  int  mon_n;
  int  mon_kind;
  ev_t mon_e;
  always @(negedge clk_RX) begin
    if (rst) begin
      mon_n = int'(data_valid) + int'(par_err) + int'(stp_err) + int'(strt_glitch);
      if (mon_n > 0) begin
        check("pulse_exclusive", mon_n, 1);
        mon_kind = data_valid ? K_VALID : par_err ? K_PAR : stp_err ? K_STP : K_GLITCH;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse kind %0d at cycle %0d, none expected", mon_kind, cyc);
        end else begin
          mon_e = expq.pop_front();
          check("pulse_kind", mon_kind, mon_e.kind);
          checks++;
          if ((cyc < mon_e.cyc - 1) || (cyc > mon_e.cyc + 1)) begin
            errors++;
            $display("FAIL pulse_cycle actual %0d expected %0d (+-1)", cyc, mon_e.cyc);
          end
          check("pulse_p_data", int'(P_DATA), int'(mon_e.pdata));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_RX);
    #1;
  endtask

  // Drives one frame starting now; spike_i=-2 picks a random spike, -1 none
  task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                            input logic ptyp, input logic pbit, input logic sbit,
                            input int spike_in, input int abort_i, input int gap);
    int          eff;
    int          nb;
    int          k;
    int          spike_i;
    logic        bad;
    logic [10:0] bits;
    prescale = PW'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    eff      = eff_of(prescale);
    nb       = pen ? 11 : 10;
    bits     = {1'b1, 1'b1, data, 1'b0};
    if (pen) begin
      bits[9]  = pbit;
      bits[10] = sbit;
    end else begin
      bits[9]  = sbit;
    end
    spike_i = spike_in;
    if (spike_in == -2) spike_i = ($urandom_range(0, 1) == 1) ? int'($urandom_range(eff, nb * eff - 2)) : -1;
    k = cyc + 1;
    if (abort_i < 0) begin
      bad = pen && (pbit != ((^data) ^ ptyp));
      if (bad) expq.push_back('{K_PAR, k + 10 * eff, model_pdata});
      if (!sbit) begin
        expq.push_back('{K_STP, k + nb * eff, model_pdata});
      end else if (!bad) begin
        model_pdata = data;
        expq.push_back('{K_VALID, k + nb * eff, data});
      end
    end
    for (int i = 0; i < nb * eff; i++) begin
      if (i == abort_i) begin
        RX_IN = 1'b1;
        rst   = 1'b0;
        model_pdata = 8'h00;
        @(negedge clk_RX);
        check_quiet("abort_reset");
        repeat (3) tick();
        rst = 1'b1;
        repeat (gap) tick();
        return;
      end
      RX_IN = bits[i / eff] ^ (i == spike_i);
      if (i == 3 * eff) begin
        PAR_EN  = 1'($urandom_range(0, 1));
        PAR_TYP = 1'($urandom_range(0, 1));
      end
      tick();
    end
    RX_IN = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic send_glitch();
    int k;
    prescale = PW'(16);
    k = cyc + 1;
    expq.push_back('{K_GLITCH, k + 16, model_pdata});
    RX_IN = 1'b0;
    repeat (3) tick();
    RX_IN = 1'b1;
    repeat (24) tick();
    check("glitch_enable_idle", int'(edge_cnt_enable), 0);
  endtask

  logic [7:0] rd;
  logic       rpen;
  logic       rtyp;
  logic       rpbit;
  logic       rsbit;
  int         rp;
  int         plist[4] = '{8, 16, 32, 12};

  initial begin
    #2 rst = 1'b0;
    repeat (3) tick();
    check_quiet("reset");
    rst = 1'b1;
    repeat (3) tick();

    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 4);
    send_frame(8'hA3, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, 4);
    send_glitch();
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 4);
    send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b0, 1'b1, 2 * 32 + 16, -1, 4);
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 0);
    send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 4);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5 * 8 + 4, 4);
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 4);

    for (int n = 0; n < 40; n++) begin
      rd    = 8'($urandom);
      rp    = plist[$urandom_range(0, 3)];
      rpen  = 1'($urandom_range(0, 1));
      rtyp  = 1'($urandom_range(0, 1));
      rpbit = ((^rd) ^ rtyp) ^ ($urandom_range(0, 4) == 0);
      rsbit = ($urandom_range(0, 9) != 0);
      send_frame(rd, rp, rpen, rtyp, rpbit, rsbit, -2, -1, int'($urandom_range(2, 12)));
    end

    for (int t = 0; (t < 2000) && (expq.size() > 0); t++) tick();
    while (expq.size() > 0) begin
      mon_e = expq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse kind %0d expected at cycle %0d, never seen", mon_e.kind, mon_e.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
